// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD pattern generator.
// Holds the pattern-mode encoding, the 3-bit colour indices and helpers that
// turn a colour index into a full {R,G,B} word of any channel width.
package lcd_pkg;

  // Run-time pattern select.
  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_GRID   = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_e;

  // Colour index: bit 2 = R, bit 1 = G, bit 0 = B (each channel full on/off).
  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  // Widest channel the expansion helper supports.
  localparam int MAX_DATA_W = 16;

  // Expand a colour index to {R,G,B}, each channel data_w bits wide, packed
  // into the low 3*data_w bits of the result (upper bits zero).
  function automatic logic [3*MAX_DATA_W-1:0] col_expand(input logic [2:0] idx,
                                                         input int data_w);
    logic [3*MAX_DATA_W-1:0] wide;
    wide = '0;
    for (int i = 0; i < 3*MAX_DATA_W; i++) begin
      if (i < data_w)        wide[i] = idx[0];
      else if (i < 2*data_w) wide[i] = idx[1];
      else if (i < 3*data_w) wide[i] = idx[2];
    end
    return wide;
  endfunction

  // Colour-bar order from the left edge of the screen.
  function automatic logic [2:0] bar_color(input logic [2:0] bar);
    logic [2:0] c;
    case (bar)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_timing_cnt.sv
// lcd_timing_cnt: free-running horizontal/vertical counters for an LCD panel.
// All outputs are combinational decodes of the counter state; the top level
// registers them so every pad signal leaves from a flop.
module lcd_timing_cnt #(
  parameter int H_TOTAL = 524,
  parameter int H_SYNC  = 40,
  parameter int H_START = 42,
  parameter int H_END   = 522,
  parameter int V_TOTAL = 285,
  parameter int V_SYNC  = 9,
  parameter int V_START = 11,
  parameter int V_END   = 283,
  parameter int X_W     = $clog2(H_END - H_START),
  parameter int Y_W     = $clog2(V_END - V_START)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           hs_o,
  output logic           vs_o,
  output logic           de_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           frame_start_o,
  output logic           frame_end_o
);

  localparam int H_W = $clog2(H_TOTAL + 1);
  localparam int V_W = $clog2(V_TOTAL + 1);

  localparam logic [H_W-1:0] H_TOTAL_C = H_W'(H_TOTAL);
  localparam logic [H_W-1:0] H_SYNC_C  = H_W'(H_SYNC);
  localparam logic [H_W-1:0] H_START_C = H_W'(H_START);
  localparam logic [H_W-1:0] H_END_C   = H_W'(H_END);
  localparam logic [V_W-1:0] V_TOTAL_C = V_W'(V_TOTAL);
  localparam logic [V_W-1:0] V_SYNC_C  = V_W'(V_SYNC);
  localparam logic [V_W-1:0] V_START_C = V_W'(V_START);
  localparam logic [V_W-1:0] V_END_C   = V_W'(V_END);

  logic [H_W-1:0] h_cnt_q;
  logic [V_W-1:0] v_cnt_q;
  logic           h_act;
  logic           v_act;

  // Pixel counter wraps each line; line counter advances on the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (h_cnt_q == H_TOTAL_C) begin
      h_cnt_q <= '0;
      v_cnt_q <= (v_cnt_q == V_TOTAL_C) ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_q <= h_cnt_q + 1'b1;
    end
  end

  // Sync, enable and coordinate decode of the current counter state.
  always_comb begin
    h_act         = (h_cnt_q >= H_START_C) && (h_cnt_q < H_END_C);
    v_act         = (v_cnt_q >= V_START_C) && (v_cnt_q < V_END_C);
    hs_o          = !(h_cnt_q <= H_SYNC_C);
    vs_o          = !(v_cnt_q <= V_SYNC_C);
    de_o          = h_act && v_act;
    x_o           = de_o ? X_W'(h_cnt_q - H_START_C) : '0;
    y_o           = de_o ? Y_W'(v_cnt_q - V_START_C) : '0;
    frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    frame_end_o   = (h_cnt_q == H_TOTAL_C) && (v_cnt_q == V_TOTAL_C);
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: parametrised LCD timing plus test-pattern generator.
// Patterns: colour bars, grid, bouncing square, solid colour. Mode, solid
// colour and square position only change at frame end, so a frame is never
// torn. Optional macro LCD_OUT_REG_EN adds one pad register stage on every
// output (latency 2 instead of 1, same reset values, outputs stay aligned).
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_TOTAL   = 524,
  parameter int H_SYNC    = 40,
  parameter int H_START   = 42,
  parameter int H_END     = 522,
  parameter int V_TOTAL   = 285,
  parameter int V_SYNC    = 9,
  parameter int V_START   = 11,
  parameter int V_END     = 283,
  parameter int DATA_W    = 8,
  parameter int SQ_SIZE   = 64,
  parameter int SQ_STEP   = 2,
  parameter int GRID_LOG2 = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         mode,
  input  logic [3*DATA_W-1:0]                solid_rgb,
  output logic                               lcd_hs,
  output logic                               lcd_vs,
  output logic                               lcd_de,
  output logic [$clog2(H_END-H_START)-1:0]   lcd_x,
  output logic [$clog2(V_END-V_START)-1:0]   lcd_y,
  output logic [3*DATA_W-1:0]                lcd_rgb,
  output logic                               frame_start
);

  localparam int SCREEN_X = H_END - H_START;
  localparam int SCREEN_Y = V_END - V_START;
  localparam int X_W      = $clog2(SCREEN_X);
  localparam int Y_W      = $clog2(SCREEN_Y);
  localparam int RGB_W    = 3 * DATA_W;
  localparam int BAR_W    = SCREEN_X / 8;
  localparam int OUT_W    = 4 + X_W + Y_W + RGB_W;

  // One extra bit on square/bar arithmetic so right/bottom edges never wrap.
  localparam logic [X_W:0]   SQ_SIZE_X  = (X_W+1)'(SQ_SIZE);
  localparam logic [Y_W:0]   SQ_SIZE_Y  = (Y_W+1)'(SQ_SIZE);
  localparam logic [X_W:0]   SQ_STEP_X  = (X_W+1)'(SQ_STEP);
  localparam logic [Y_W:0]   SQ_STEP_Y  = (Y_W+1)'(SQ_STEP);
  localparam logic [X_W:0]   SX_LIM     = (X_W+1)'(SCREEN_X - SQ_SIZE);
  localparam logic [Y_W:0]   SY_LIM     = (Y_W+1)'(SCREEN_Y - SQ_SIZE);
  localparam logic [X_W:0]   BARS_END   = (X_W+1)'(8 * BAR_W);
  localparam logic [X_W-1:0] BAR_W_X    = X_W'(BAR_W);

  // Elaboration-time parameter sanity.
  if (!(H_SYNC < H_START && H_START < H_END && H_END <= H_TOTAL)) begin : g_bad_h
    $error("lcd_pattern_gen: horizontal timing parameters out of order");
  end
  if (!(V_SYNC < V_START && V_START < V_END && V_END <= V_TOTAL)) begin : g_bad_v
    $error("lcd_pattern_gen: vertical timing parameters out of order");
  end
  if (!(SQ_SIZE < SCREEN_X && SQ_SIZE < SCREEN_Y)) begin : g_bad_sq
    $error("lcd_pattern_gen: SQ_SIZE must be smaller than both screen axes");
  end
  if (!(SCREEN_X >= 8 && DATA_W <= MAX_DATA_W && GRID_LOG2 >= 1 &&
        GRID_LOG2 <= X_W && GRID_LOG2 <= Y_W)) begin : g_bad_misc
    $error("lcd_pattern_gen: DATA_W, GRID_LOG2 or screen width unsupported");
  end

  logic           t_hs, t_vs, t_de, t_fs, t_fe;
  logic [X_W-1:0] t_x;
  logic [Y_W-1:0] t_y;

  lcd_timing_cnt #(
    .H_TOTAL (H_TOTAL), .H_SYNC (H_SYNC), .H_START (H_START), .H_END (H_END),
    .V_TOTAL (V_TOTAL), .V_SYNC (V_SYNC), .V_START (V_START), .V_END (V_END),
    .X_W     (X_W),     .Y_W    (Y_W)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .hs_o          (t_hs),
    .vs_o          (t_vs),
    .de_o          (t_de),
    .x_o           (t_x),
    .y_o           (t_y),
    .frame_start_o (t_fs),
    .frame_end_o   (t_fe)
  );

  // Per-frame state: latched mode/colour and square position (dir 1 = moving negative).
  mode_e             mode_q;
  logic [RGB_W-1:0]  solid_q;
  logic [X_W-1:0]    sq_x_q, sq_x_d;
  logic [Y_W-1:0]    sq_y_q, sq_y_d;
  logic              dir_x_q, dir_x_d;
  logic              dir_y_q, dir_y_d;

  // Next square position: step per axis, clamp and reverse at the screen edges.
  always_comb begin
    sq_x_d  = sq_x_q;
    dir_x_d = dir_x_q;
    sq_y_d  = sq_y_q;
    dir_y_d = dir_y_q;
    if (!dir_x_q) begin
      if (({1'b0, sq_x_q} + SQ_STEP_X) >= SX_LIM) begin
        sq_x_d  = X_W'(SCREEN_X - SQ_SIZE);
        dir_x_d = 1'b1;
      end else begin
        sq_x_d = sq_x_q + X_W'(SQ_STEP);
      end
    end else begin
      if ({1'b0, sq_x_q} <= SQ_STEP_X) begin
        sq_x_d  = '0;
        dir_x_d = 1'b0;
      end else begin
        sq_x_d = sq_x_q - X_W'(SQ_STEP);
      end
    end
    if (!dir_y_q) begin
      if (({1'b0, sq_y_q} + SQ_STEP_Y) >= SY_LIM) begin
        sq_y_d  = Y_W'(SCREEN_Y - SQ_SIZE);
        dir_y_d = 1'b1;
      end else begin
        sq_y_d = sq_y_q + Y_W'(SQ_STEP);
      end
    end else begin
      if ({1'b0, sq_y_q} <= SQ_STEP_Y) begin
        sq_y_d  = '0;
        dir_y_d = 1'b0;
      end else begin
        sq_y_d = sq_y_q - Y_W'(SQ_STEP);
      end
    end
  end

  // Frame-end update: sample mode/colour and move the square (in every mode).
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_BARS;
      solid_q <= '0;
      sq_x_q  <= '0;
      sq_y_q  <= '0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
    end else if (t_fe) begin
      mode_q  <= mode_e'(mode);
      solid_q <= solid_rgb;
      sq_x_q  <= sq_x_d;
      sq_y_q  <= sq_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  logic [2:0]       col_idx;
  logic             in_sq;
  logic [RGB_W-1:0] rgb_d;

  // Pattern mux for the current pixel; blank outside the active region.
  always_comb begin
    in_sq = ({1'b0, t_x} >= {1'b0, sq_x_q}) && ({1'b0, t_x} < ({1'b0, sq_x_q} + SQ_SIZE_X)) &&
            ({1'b0, t_y} >= {1'b0, sq_y_q}) && ({1'b0, t_y} < ({1'b0, sq_y_q} + SQ_SIZE_Y));
    col_idx = COL_BLACK;
    case (mode_q)
      MODE_BARS:   col_idx = ({1'b0, t_x} >= BARS_END) ? COL_BLACK
                                                       : bar_color(3'(t_x / BAR_W_X));
      MODE_GRID:   col_idx = ((t_x[GRID_LOG2-1:0] == '0) || (t_y[GRID_LOG2-1:0] == '0))
                             ? COL_WHITE : COL_BLACK;
      MODE_SQUARE: col_idx = in_sq ? COL_WHITE : COL_BLUE;
      default:     col_idx = COL_BLACK;
    endcase
    rgb_d = (mode_q == MODE_SOLID) ? solid_q : RGB_W'(col_expand(col_idx, DATA_W));
    if (!t_de) rgb_d = '0;
  end

  logic             hs_q, vs_q, de_q, fs_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [RGB_W-1:0] rgb_q;

  // Output registers: every pad signal comes from a flop, all on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      rgb_q <= '0;
    end else begin
      hs_q  <= t_hs;
      vs_q  <= t_vs;
      de_q  <= t_de;
      fs_q  <= t_fs;
      x_q   <= t_x;
      y_q   <= t_y;
      rgb_q <= rgb_d;
    end
  end

  logic [OUT_W-1:0] stage1;
  logic [OUT_W-1:0] out_bus;
  assign stage1 = {hs_q, vs_q, de_q, fs_q, x_q, y_q, rgb_q};

`ifdef LCD_OUT_REG_EN
  localparam logic [OUT_W-1:0] OUT_RST = {1'b1, 1'b1, 1'b0, 1'b0, {(OUT_W-4){1'b0}}};
  logic [OUT_W-1:0] pad_q;

  // Extra pad stage delaying the whole output bundle by one cycle.
  always_ff @(posedge clk) begin
    if (rst) pad_q <= OUT_RST;
    else     pad_q <= stage1;
  end
  assign out_bus = pad_q;
`else
  assign out_bus = stage1;
`endif

  assign {lcd_hs, lcd_vs, lcd_de, frame_start, lcd_x, lcd_y, lcd_rgb} = out_bus;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen: two instances. dut_s uses a small panel so whole
// frames can be checked cycle-by-cycle against a frame-level model; dut_d
// uses default geometry and is checked with literal timing/bar values over
// the first lines of its first frame.
`timescale 1ns/1ps
module tb_lcd_pattern_gen;

`ifdef LCD_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Small panel geometry.
  localparam int S_HT = 39, S_HS = 3, S_HST = 6, S_HEN = 38;
  localparam int S_VT = 29, S_VS = 1, S_VST = 3, S_VEN = 27;
  localparam int S_SX = S_HEN - S_HST;   // 32
  localparam int S_SY = S_VEN - S_VST;   // 24
  localparam int S_SQ = 8, S_STEP = 3, S_GRID = 2;
  localparam int S_LINE = S_HT + 1;
  localparam int S_F = S_LINE * (S_VT + 1);
  localparam int MAXF = 64;
  localparam logic [37:0] RESET_V = {1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 24'd0, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUTs ----------------
  logic [1:0]  mode_s, mode_d;
  logic [23:0] solid_s, solid_d;
  logic        hs_s, vs_s, de_s, fs_s;
  logic [4:0]  x_s, y_s;
  logic [23:0] rgb_s;
  logic        hs_d, vs_d, de_d, fs_d;
  logic [8:0]  x_d, y_d;
  logic [23:0] rgb_d;

  lcd_pattern_gen #(
    .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_START(S_HST), .H_END(S_HEN),
    .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_START(S_VST), .V_END(S_VEN),
    .DATA_W(8), .SQ_SIZE(S_SQ), .SQ_STEP(S_STEP), .GRID_LOG2(S_GRID)
  ) dut_s (
    .clk(clk), .rst(rst), .mode(mode_s), .solid_rgb(solid_s),
    .lcd_hs(hs_s), .lcd_vs(vs_s), .lcd_de(de_s), .lcd_x(x_s), .lcd_y(y_s),
    .lcd_rgb(rgb_s), .frame_start(fs_s)
  );

  lcd_pattern_gen dut_d (
    .clk(clk), .rst(rst), .mode(mode_d), .solid_rgb(solid_d),
    .lcd_hs(hs_d), .lcd_vs(vs_d), .lcd_de(de_d), .lcd_x(x_d), .lcd_y(y_d),
    .lcd_rgb(rgb_d), .frame_start(fs_d)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  int fails_printed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else begin
      if (fails_printed < 30)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      fails_printed++;
    end
  endtask

  // ---------------- frame-level model of dut_s ----------------
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int          fr_mode  [MAXF];
  logic [23:0] fr_solid [MAXF];
  int          fr_sqx   [MAXF];
  int          fr_sqy   [MAXF];
  bit          fr_dx    [MAXF];
  bit          fr_dy    [MAXF];
  bit          model_live = 0;
  int          run_id = 0;
  bit          d_done = 0;
  bit hit_sq_w = 0, hit_sq_b = 0, hit_solid1 = 0, hit_solid2 = 0, hit_post_rst = 0;

  // Bounce rule for one axis: neg=1 means moving towards 0.
  function automatic void axis_step(input int pos, input bit neg, input int screen,
                                    output int npos, output bit nneg);
    int lim;
    lim = screen - S_SQ;
    if (!neg) begin
      if (pos + S_STEP >= lim) begin npos = lim; nneg = 1; end
      else begin npos = pos + S_STEP; nneg = 0; end
    end else begin
      if (pos <= S_STEP) begin npos = 0; nneg = 0; end
      else begin npos = pos - S_STEP; nneg = 1; end
    end
  endfunction

  // Expected {hs,vs,de,x,y,rgb,fs} for the s-th cycle after reset release.
  function automatic logic [37:0] model_out(input int s);
    int f, p, h, v, x, y, b;
    bit de;
    logic [23:0] rgb;
    f = s / S_F;
    if (f >= MAXF) f = MAXF - 1;
    p = s % S_F;
    h = p % S_LINE;
    v = p / S_LINE;
    de = (h >= S_HST) && (h < S_HEN) && (v >= S_VST) && (v < S_VEN);
    x = de ? h - S_HST : 0;
    y = de ? v - S_VST : 0;
    rgb = 24'h0;
    if (de) begin
      case (fr_mode[f])
        0: begin b = x / (S_SX / 8); rgb = (b < 8) ? bar_tab[b] : 24'h0; end
        1: rgb = ((x % (1 << S_GRID)) == 0 || (y % (1 << S_GRID)) == 0) ? 24'hFFFFFF : 24'h0;
        2: rgb = (x >= fr_sqx[f] && x < fr_sqx[f] + S_SQ &&
                  y >= fr_sqy[f] && y < fr_sqy[f] + S_SQ) ? 24'hFFFFFF : 24'h0000FF;
        default: rgb = fr_solid[f];
      endcase
    end
    return {(h > S_HS), (v > S_VS), de, 5'(x), 5'(y), rgb, (p == 0)};
  endfunction

  // Per-cycle compare of dut_s against the model.
  initial begin : mon_s
    int n, fe, s, f;
    logic [37:0] exp_v, got_v;
    n = 0;
    exp_v = RESET_V;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b1) begin
        n = 0;
        model_live = 1;
        fr_mode[0] = 0; fr_solid[0] = 24'h0;
        fr_sqx[0] = 0; fr_sqy[0] = 0; fr_dx[0] = 0; fr_dy[0] = 0;
        exp_v = RESET_V;
      end else if (model_live) begin
        n++;
        if ((n - 1) % S_F == S_F - 1) begin
          fe = (n - 1) / S_F;
          if (fe + 1 < MAXF) begin
            fr_mode[fe+1]  = int'(mode_s);
            fr_solid[fe+1] = solid_s;
            axis_step(fr_sqx[fe], fr_dx[fe], S_SX, fr_sqx[fe+1], fr_dx[fe+1]);
            axis_step(fr_sqy[fe], fr_dy[fe], S_SY, fr_sqy[fe+1], fr_dy[fe+1]);
          end
        end
        exp_v = (n < LAT) ? RESET_V : model_out(n - LAT);
        if (n >= LAT && de_s === 1'b1) begin
          s = n - LAT;
          f = s / S_F;
          if (run_id == 0 && f == 9 && x_s == 5'd21 && y_s == 5'd7) begin
            check("sq_inside_px", rgb_s, 24'hFFFFFF); hit_sq_w = 1;
          end
          if (run_id == 0 && f == 9 && x_s == 5'd29 && y_s == 5'd7) begin
            check("sq_outside_px", rgb_s, 24'h0000FF); hit_sq_b = 1;
          end
          if (run_id == 0 && f == 1 && x_s == 5'd0 && y_s == 5'd0) begin
            check("solid_frame1", rgb_s, 24'h123456); hit_solid1 = 1;
          end
          if (run_id == 0 && f == 2 && x_s == 5'd0 && y_s == 5'd0) begin
            check("solid_frame2", rgb_s, 24'hABCDEF); hit_solid2 = 1;
          end
          if (run_id == 1 && f == 0 && x_s == 5'd5 && y_s == 5'd0) begin
            check("bars_after_reset", rgb_s, 24'hFFFF00); hit_post_rst = 1;
          end
        end
      end
      if (model_live) begin
        got_v = {hs_s, vs_s, de_s, x_s, y_s, rgb_s, fs_s};
        check("dut_s_cycle", got_v, exp_v);
      end
    end
  end

  // Literal checks on the default-geometry instance.
  initial begin : mon_d
    int n, hs_low, vs_low, fall1, fall2, de_line, de_early, fs_extra;
    bit seen, prev_hs, h59, h60, h479;
    wait (rst === 1'b1);
    @(posedge clk); #1;
    check("d_reset_outputs", {hs_d, vs_d, de_d, fs_d, x_d, y_d, rgb_d},
          {1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 24'h0});
    n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (rst === 1'b0) begin
        n++;
        if (fs_d === 1'b1) seen = 1;
      end
    end
    check("d_first_frame_start", n, LAT);
    hs_low = 0; vs_low = 0; fall1 = -1; fall2 = -1; de_line = 0; de_early = 0;
    fs_extra = 0; prev_hs = 1; h59 = 0; h60 = 0; h479 = 0;
    for (int o = 0; o < 12 * 525; o++) begin
      if (o > 0) begin @(posedge clk); #1; end
      if (o < 525 && hs_d === 1'b0) hs_low++;
      if (vs_d === 1'b0) vs_low++;
      if (prev_hs && hs_d === 1'b0) begin
        if (fall1 < 0) fall1 = o;
        else if (fall2 < 0) fall2 = o;
      end
      prev_hs = hs_d;
      if (o < 11 * 525 && de_d === 1'b1) de_early++;
      if (o >= 11 * 525 && de_d === 1'b1) de_line++;
      if (o > 0 && fs_d === 1'b1) fs_extra++;
      if (de_d === 1'b1 && y_d == 9'd0) begin
        if (x_d == 9'd59)  begin check("d_bar_x59",  rgb_d, 24'hFFFFFF); h59 = 1; end
        if (x_d == 9'd60)  begin check("d_bar_x60",  rgb_d, 24'hFFFF00); h60 = 1; end
        if (x_d == 9'd479) begin check("d_bar_x479", rgb_d, 24'h000000); h479 = 1; end
      end
    end
    check("d_hs_low_cycles", hs_low, 41);
    check("d_line_period", fall2 - fall1, 525);
    check("d_vs_low_cycles", vs_low, 10 * 525);
    check("d_de_before_active", de_early, 0);
    check("d_de_per_line", de_line, 480);
    check("d_frame_start_once", fs_extra, 0);
    check("d_bar_pixels_seen", {h59, h60, h479}, 3'b111);
    d_done = 1;
  end

  // ---------------- driver ----------------
  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin : drive
    rst = 1'b1;
    mode_s = 2'd0; solid_s = 24'h0;
    mode_d = 2'd0; solid_d = 24'h0;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(S_F / 2);            // mid frame 0
    mode_s = 2'd3; solid_s = 24'h123456;
    wait_cycles(S_F);                // mid frame 1: colour change must wait for frame 2
    solid_s = 24'hABCDEF;
    wait_cycles(S_F);                // mid frame 2
    mode_s = 2'd1;
    wait_cycles(S_F);                // mid frame 3
    mode_s = 2'd2;
    wait_cycles(10 * S_F);           // mid frame 13
    mode_s = 2'd0;
    wait_cycles(S_F);                // mid frame 14
    check("model_sqx_f8", fr_sqx[8], 24);
    check("model_sqx_f9", fr_sqx[9], 21);
    check("model_sqy_f6", fr_sqy[6], 16);
    check("model_sqy_f9", fr_sqy[9], 7);
    mode_s = 2'd2;                   // mode_q must still restart at bars
    run_id = 1;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(S_F * 5 / 2);
    check("seen_sq_inside", hit_sq_w, 1'b1);
    check("seen_sq_outside", hit_sq_b, 1'b1);
    check("seen_solid_f1", hit_solid1, 1'b1);
    check("seen_solid_f2", hit_solid2, 1'b1);
    check("seen_bars_post_rst", hit_post_rst, 1'b1);
    check("default_inst_done", d_done, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lcd_pattern_gen.md
# lcd_pattern_gen

Parametrised successor to the fixed 480x272 VGA_GEN timing generator. Produces HS/VS/DE timing for any panel from generic counter parameters and drives one of four run-time-selectable test patterns: colour bars, grid, bouncing square, solid colour. It sits between the pixel-clock source and the LCD pad interface. It also exports pixel coordinates and a frame-start strobe for downstream overlay logic.

## Interface
Parameters:
- H_TOTAL, 524, last horizontal count (line length minus 1)
- H_SYNC, 40, last count of the HS pulse
- H_START, 42, first active horizontal count
- H_END, 522, first horizontal count after the active region
- V_TOTAL, 285, last vertical count
- V_SYNC, 9, last count of the VS pulse
- V_START, 11, first active line
- V_END, 283, first line after the active region
- DATA_W, 8, bits per colour channel
- SQ_SIZE, 64, bouncing-square edge length in pixels
- SQ_STEP, 2, square displacement per frame, per axis
- GRID_LOG2, 5, grid pitch of 2^GRID_LOG2 pixels

Derived values:
- SCREEN_X = H_END-H_START
- SCREEN_Y = V_END-V_START
- X_W = $clog2(SCREEN_X)
- Y_W = $clog2(SCREEN_Y)

Ports:
- clk  in  1  pixel clock, the only clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  pattern select: 0 bars, 1 grid, 2 square, 3 solid
- solid_rgb  in  3*DATA_W  colour used in mode 3
- lcd_hs  out  1  horizontal sync, active low
- lcd_vs  out  1  vertical sync, active low
- lcd_de  out  1  data enable
- lcd_x  out  X_W  active pixel column, 0 outside the active region
- lcd_y  out  Y_W  active pixel row, 0 outside the active region
- lcd_rgb  out  3*DATA_W  pixel data {R,G,B}, R in the MSBs
- frame_start  out  1  one-cycle pulse on the first cycle of each frame

## Operation
Counters:
- h_cnt runs 0..H_TOTAL and wraps to 0.
- v_cnt increments when h_cnt wraps; it runs 0..V_TOTAL and wraps to 0.

Timing signals:
- hs is 0 while h_cnt <= H_SYNC.
- vs is 0 while v_cnt <= V_SYNC.
- de is 1 while H_START <= h_cnt < H_END and V_START <= v_cnt < V_END.
- In the active region, x = h_cnt-H_START and y = v_cnt-V_START.
- frame_start is 1 when h_cnt==0 and v_cnt==0.

Frame end:
- Frame end is the cycle with h_cnt==H_TOTAL and v_cnt==V_TOTAL.
- At frame end, mode is sampled into mode_q and the square position is updated.
- A mode change mid-frame has no visible effect until the next frame.

Patterns:
- Bars: 8 equal columns of width SCREEN_X/8. Order is white, yellow, cyan, green, magenta, red, blue, black. Any remainder columns are black.
- Grid: white when x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, black otherwise.
- Square: white inside sq_x <= x < sq_x+SQ_SIZE and sq_y <= y < sq_y+SQ_SIZE, blue elsewhere.
- Solid: solid_rgb, registered at frame end together with mode.
- lcd_rgb is 0 whenever de is 0.

Square motion (per axis; X shown, Y identical with SCREEN_Y):
- Moving positive: if sq_x+SQ_STEP >= SCREEN_X-SQ_SIZE, set sq_x = SCREEN_X-SQ_SIZE and flip direction. Otherwise add SQ_STEP.
- Moving negative: if sq_x <= SQ_STEP, set sq_x = 0 and flip direction. Otherwise subtract SQ_STEP.
- Position updates in every mode, so motion continues while the square is not shown.

Reset (rst=1 at a clock edge):
- Counters, sq_x and sq_y go to 0; direction goes to +,+; mode_q goes to 0.
- Outputs go to lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_x=0, lcd_y=0, lcd_rgb=0, frame_start=0.
- Reset mid-frame abandons the frame. The first cycle after release is h_cnt=0, v_cnt=0.

Parameter checks (elaboration-time assertions):
- H_SYNC < H_START < H_END <= H_TOTAL, and the same ordering for the V parameters.
- SQ_SIZE < min(SCREEN_X, SCREEN_Y).

## Timing
- All outputs are registered. They reflect the counter state of the previous cycle, a latency of 1.
- All outputs are mutually aligned, so hs, vs, de, x, y, rgb and frame_start change on the same edge.
- Line period is H_TOTAL+1 cycles; frame period is (H_TOTAL+1)*(V_TOTAL+1) cycles.
- The first frame_start occurs 1 cycle after reset release (latency 2 with the macro below).

## Configuration
- LCD_OUT_REG_EN defined: one extra register stage on every output, for pad timing. Latency becomes 2, reset values are unchanged, and all outputs stay aligned.
- LCD_OUT_REG_EN undefined: latency 1.

## Structure
- Package lcd_pkg holds the mode encoding (MODE_BARS=0, MODE_GRID=1, MODE_SQUARE=2, MODE_SOLID=3) and the 3-bit colour index constants with their expansion function to 3*DATA_W.
- Sub-module lcd_timing_cnt holds the h/v counters and produces hs, vs, de, x, y, frame_start and frame_end, all unregistered.
- The top level holds mode_q, the square state, pattern muxing and the output registers.

## Test plan
- Reset: hold rst 5 cycles with default parameters -> outputs hs=1, vs=1, de=0, rgb=0. The first frame_start occurs 1 cycle after release.
- Timing: run 2 frames -> line period 525 cycles, hs low 41 cycles, de high 480 cycles per line on 272 lines, frame period 150150 cycles.
- Bars, mode 0 with DATA_W=8 -> x=59 gives rgb=24'hFFFFFF, x=60 gives 24'hFFFF00, x=479 gives 24'h000000.
- Square with SCREEN_X=480, SQ_SIZE=64, SQ_STEP=2 -> sq_x reaches 416 after 208 frames, then reads 414 on the next frame. Pixel (sq_x, sq_y) is white and (sq_x+64, sq_y) is blue.
- Mode switch: change mode 0->3 with solid_rgb=24'h123456 mid-frame -> no change until the next frame_start, then every active pixel is 24'h123456.
- Macro: build with LCD_OUT_REG_EN -> every output is delayed exactly 1 cycle against the default build, with identical waveforms otherwise.
